shift_reg_bank_async: RTL and testbench

//  Parametrised WIDTH-bit register bank with async clear, sync preset and complementary outputs.

---
 rtl/shift_reg_bank_async.sv | 146 ++++++++++++++
 tb/tb_shift_reg_bank_async.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_bank_async.sv
// WIDTH-bit shift/rotate register bank with async clear, sync preset,
// single-step and counted burst operation with busy/done handshake.
module shift_reg_bank_async #(
  parameter int unsigned         WIDTH      = 8,
  parameter logic [WIDTH-1:0]    PRESET_VAL = {WIDTH{1'b1}},
  localparam int unsigned        SW         = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             prst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in,
  input  logic             start,
  input  logic [SW-1:0]    shamt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_SHR  = 3'd3;
  localparam logic [2:0] M_ROTL = 3'd4;
  localparam logic [2:0] M_ROTR = 3'd5;
  localparam logic [2:0] M_ASR  = 3'd6;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [2:0]       lmode_q, lmode_d;

  logic [2:0]       step_mode;
  logic [WIDTH:0]   step_res;
  logic             is_shift;
  logic [SW-1:0]    sat_cnt;

  // Returns {ser_out, q} after one step of mode m.
  function automatic logic [WIDTH:0] step_f(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] ld,
    input logic             si,
    input logic             so
  );
    logic [WIDTH:0] r;
    r = {so, v};
    case (m)
      M_LOAD: r = {so, ld};
      M_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], si};
      M_SHR:  r = {v[0], si, v[WIDTH-1:1]};
      M_ROTL: r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      M_ROTR: r = {v[0], v[0], v[WIDTH-1:1]};
      M_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {so, v};
    endcase
    return r;
  endfunction

  always_comb begin
    is_shift  = (mode >= M_SHL) && (mode <= M_ASR);
    sat_cnt   = (shamt > SW'(WIDTH)) ? SW'(WIDTH) : shamt;
    step_mode = (state_q == S_RUN) ? lmode_q : mode;
    step_res  = step_f(step_mode, q_q, d_in, ser_in, ser_q);
  end

  always_comb begin
    q_d     = q_q;
    ser_d   = ser_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    lmode_d = lmode_q;
    if (!prst) begin
      q_d     = PRESET_VAL;
      ser_d   = 1'b0;
      busy_d  = 1'b0;
      state_d = S_IDLE;
    end else if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (start && is_shift && (shamt != '0)) begin
            lmode_d = mode;
            cnt_d   = sat_cnt;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            {ser_d, q_d} = step_res;
            done_d       = start;
          end
        end
        S_RUN: begin
          {ser_d, q_d} = step_res;
          cnt_d        = cnt_q - SW'(1);
          // Final step of the burst releases busy and pulses done.
          if (cnt_q == SW'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      lmode_q <= M_HOLD;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      lmode_q <= lmode_d;
    end
  end

  assign q       = q_q;
  assign q_bar   = ~q_q;
  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_bank_async.sv
// Directed bench for shift_reg_bank_async, WIDTH=8.
// Expected values are hand computed from the register behaviour.
module tb_shift_reg_bank_async;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         prst;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d_in;
  logic         ser_in;
  logic         start;
  logic [3:0]   shamt;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         ser_out;
  logic         busy;
  logic         done;

  int n_chk  = 0;
  int n_pass = 0;

  shift_reg_bank_async #(.WIDTH(W)) dut (
    .clk     (clk),
    .clr     (clr),
    .prst    (prst),
    .en      (en),
    .mode    (mode),
    .d_in    (d_in),
    .ser_in  (ser_in),
    .start   (start),
    .shamt   (shamt),
    .q       (q),
    .q_bar   (q_bar),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    mode  = 3'd1;
    d_in  = v;
    start = 1'b0;
    en    = 1'b1;
    tick();
    mode  = 3'd0;
  endtask

  task automatic burst(input string tag, input logic [2:0] m,
                       input logic [3:0] sa, input int exp_n);
    int n;
    mode  = m;
    shamt = sa;
    start = 1'b1;
    en    = 1'b1;
    tick();
    start = 1'b0;
    mode  = 3'd0;
    chk({tag, "_busy_acc"}, busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_steps"}, n, exp_n);
    chk({tag, "_done"}, done, 1);
  endtask

  initial begin
    clr    = 1'b0;
    prst   = 1'b1;
    en     = 1'b0;
    mode   = 3'd0;
    d_in   = '0;
    ser_in = 1'b0;
    start  = 1'b0;
    shamt  = '0;
    #12;
    chk("rst_q", q, 8'h00);
    chk("rst_qbar", q_bar, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    clr = 1'b1;
    tick();

    // async clear mid-cycle
    load(8'hA5);
    chk("load_q", q, 8'hA5);
    chk("load_qbar", q_bar, 8'h5A);
    #2 clr = 1'b0;
    #1;
    chk("aclr_q", q, 8'h00);
    chk("aclr_qbar", q_bar, 8'hFF);
    chk("aclr_busy", busy, 0);
    #1 clr = 1'b1;

    // SHL burst of 3 with ser_in=1
    load(8'h81);
    ser_in = 1'b1;
    burst("shl3", 3'd2, 4'd3, 3);
    chk("shl3_q", q, 8'h0F);
    chk("shl3_ser", ser_out, 0);
    tick();
    chk("shl3_done_clr", done, 0);
    ser_in = 1'b0;

    // rotate by WIDTH returns original
    load(8'h3C);
    burst("rotr8", 3'd5, 4'd8, 8);
    chk("rotr8_q", q, 8'h3C);
    tick();

    load(8'h90);
    burst("asr2", 3'd6, 4'd2, 2);
    chk("asr2_q", q, 8'hE4);
    chk("asr2_ser", ser_out, 0);
    tick();

    // single steps
    load(8'h96);
    mode = 3'd4;
    tick();
    chk("rotl1_q", q, 8'h2D);
    chk("rotl1_ser", ser_out, 1);
    mode = 3'd3;
    ser_in = 1'b1;
    tick();
    chk("shr1_q", q, 8'h96);
    chk("shr1_ser", ser_out, 1);
    ser_in = 1'b0;
    mode = 3'd7;
    tick();
    chk("nop_q", q, 8'h96);
    chk("nop_ser", ser_out, 1);
    mode = 3'd1;
    d_in = 8'h11;
    en = 1'b0;
    tick();
    chk("en0_q", q, 8'h96);
    en = 1'b1;
    mode = 3'd0;

    // preset aborts a burst
    load(8'h81);
    mode  = 3'd4;
    shamt = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_mid_q", q, 8'h06);
    prst = 1'b0;
    en   = 1'b0;
    tick();
    prst = 1'b1;
    en   = 1'b1;
    mode = 3'd0;
    chk("pre_q", q, 8'hFF);
    chk("pre_busy", busy, 0);
    chk("pre_done", done, 0);
    chk("pre_ser", ser_out, 0);
    tick();
    chk("pre_done2", done, 0);
    chk("pre_hold", q, 8'hFF);

    // SHR burst with a 3-cycle stall
    load(8'hF0);
    mode  = 3'd3;
    shamt = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 3'd0;
    tick();
    tick();
    chk("stall_pre_q", q, 8'h3C);
    en = 1'b0;
    tick();
    tick();
    tick();
    chk("stall_q", q, 8'h3C);
    chk("stall_busy", busy, 1);
    chk("stall_done", done, 0);
    en = 1'b1;
    tick();
    chk("stall_s3_q", q, 8'h1E);
    chk("stall_s3_busy", busy, 1);
    tick();
    chk("stall_end_q", q, 8'h0F);
    chk("stall_end_busy", busy, 0);
    chk("stall_end_done", done, 1);
    tick();

    // shamt=0 completes immediately
    load(8'h5A);
    mode  = 3'd0;
    shamt = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sh0_q", q, 8'h5A);
    chk("sh0_done", done, 1);
    chk("sh0_busy", busy, 0);
    tick();
    chk("sh0_done_clr", done, 0);

    // shamt saturates at WIDTH
    load(8'h12);
    burst("sat", 3'd4, 4'd15, 8);
    chk("sat_q", q, 8'h12);
    tick();

    // async clear aborts burst with no done
    load(8'h81);
    mode  = 3'd4;
    shamt = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 3'd0;
    tick();
    #2 clr = 1'b0;
    #1;
    chk("clr_burst_busy", busy, 0);
    chk("clr_burst_q", q, 8'h00);
    #1 clr = 1'b1;
    tick();
    chk("clr_burst_done", done, 0);
    chk("clr_burst_busy2", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
